hamming_serial_decoder: RTL and testbench

//  Receive side of the team's 5-bit/10-bit Hamming link. Deserializes a bit stream into
//  10-bit codewords, computes the syndrome and corrects single-bit errors. Flags

---
 rtl/hamming_serial_decoder.sv | 169 ++++++++++++++++
 tb/tb_hamming_serial_decoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/hamming_serial_decoder.sv
`default_nettype none
// ============================================================================
// Module   : hamming_serial_decoder
// Brief    : Serial receiver for the 5b/10b Hamming link; corrects single-bit
//            errors, flags uncorrectable words, hands 5 data bits out over
//            valid/ready. Optional error statistics: HAMMING_DEC_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hamming_serial_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             in_valid,
    input  logic             in_bit,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [4:0]       data_out,
    output logic [9:0]       code_out,
    output logic [3:0]       error_index,
    output logic             multiple_error,
    output logic [CNT_W-1:0] corr_cnt,
    output logic [CNT_W-1:0] uncorr_cnt
);

    localparam logic [1:0] ST_SHIFT   = 2'd0;
    localparam logic [1:0] ST_DECODE  = 2'd1;
    localparam logic [1:0] ST_HOLD    = 2'd2;
    localparam logic [3:0] C_LAST_BIT = 4'd9;
    localparam logic [3:0] C_IDX_C0   = 4'd10;

    logic [1:0] r_state;
    logic [3:0] r_bit_cnt;
    logic [9:0] r_sreg;
    logic       r_out_valid;
    logic [4:0] r_data;
    logic [9:0] r_code;
    logic [3:0] r_index;
    logic       r_multi;

    logic [3:0] w_syn;
    logic       w_par;
    logic [3:0] w_index;
    logic       w_multi;
    logic [9:0] w_flip;
    logic [9:0] w_corr;
    logic [4:0] w_data;

    // Syndrome bit k covers every position whose index (10 - bit) has bit k set.
    assign w_syn[0] = r_sreg[9] ^ r_sreg[7] ^ r_sreg[5] ^ r_sreg[3] ^ r_sreg[1];
    assign w_syn[1] = r_sreg[8] ^ r_sreg[7] ^ r_sreg[4] ^ r_sreg[3];
    assign w_syn[2] = r_sreg[6] ^ r_sreg[5] ^ r_sreg[4] ^ r_sreg[3];
    assign w_syn[3] = r_sreg[2] ^ r_sreg[1];
    assign w_par    = ^r_sreg;

    always_comb begin
        w_index = 4'd0;
        w_multi = 1'b0;
        if (w_syn == 4'd0) begin
            w_index = w_par ? C_IDX_C0 : 4'd0;
        end else if (w_par && (w_syn <= 4'd9)) begin
            w_index = w_syn;
        end else begin
            w_multi = 1'b1;
        end
    end

    always_comb begin
        w_flip = '0;
        for (int i = 0; i < 10; i++) begin
            if ((w_index != 4'd0) && (w_index == 4'(10 - i))) begin
                w_flip[i] = 1'b1;
            end
        end
    end

    assign w_corr = r_sreg ^ w_flip;
    assign w_data = {w_corr[7], w_corr[5], w_corr[4], w_corr[3], w_corr[1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SHIFT;
            r_bit_cnt   <= 4'd0;
            r_sreg      <= 10'd0;
            r_out_valid <= 1'b0;
            r_data      <= 5'd0;
            r_code      <= 10'd0;
            r_index     <= 4'd0;
            r_multi     <= 1'b0;
        end else if (clr) begin
            r_state     <= ST_SHIFT;
            r_bit_cnt   <= 4'd0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_SHIFT: begin
                    if (in_valid) begin
                        r_sreg <= {r_sreg[8:0], in_bit};
                        if (r_bit_cnt == C_LAST_BIT) begin
                            r_bit_cnt <= 4'd0;
                            r_state   <= ST_DECODE;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                        end
                    end
                end
                ST_DECODE: begin
                    r_data      <= w_data;
                    r_code      <= w_corr;
                    r_index     <= w_index;
                    r_multi     <= w_multi;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_SHIFT;
                    end
                end
                default: begin
                    r_state     <= ST_SHIFT;
                    r_bit_cnt   <= 4'd0;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef HAMMING_DEC_STATS_EN
    logic [CNT_W-1:0] r_corr_cnt;
    logic [CNT_W-1:0] r_uncorr_cnt;
    logic             w_leave_decode;

    // clr in DECODE discards the word, so it is not counted.
    assign w_leave_decode = (r_state == ST_DECODE) && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_corr_cnt   <= '0;
            r_uncorr_cnt <= '0;
        end else if (w_leave_decode) begin
            if ((w_index != 4'd0) && (r_corr_cnt != {CNT_W{1'b1}})) begin
                r_corr_cnt <= r_corr_cnt + CNT_W'(1);
            end
            if (w_multi && (r_uncorr_cnt != {CNT_W{1'b1}})) begin
                r_uncorr_cnt <= r_uncorr_cnt + CNT_W'(1);
            end
        end
    end

    assign corr_cnt   = r_corr_cnt;
    assign uncorr_cnt = r_uncorr_cnt;
`else
    assign corr_cnt   = '0;
    assign uncorr_cnt = '0;
`endif

    assign in_ready       = (r_state == ST_SHIFT);
    assign out_valid      = r_out_valid;
    assign data_out       = r_data;
    assign code_out       = r_code;
    assign error_index    = r_index;
    assign multiple_error = r_multi;

endmodule
`default_nettype wire

// File: tb/tb_hamming_serial_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_hamming_serial_decoder
// Brief    : Directed self-checking bench for hamming_serial_decoder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hamming_serial_decoder;

    localparam int CNT_W_TB = 2;

    logic                clk;
    logic                rst_n;
    logic                clr;
    logic                in_valid;
    logic                in_bit;
    logic                in_ready;
    logic                out_valid;
    logic                out_ready;
    logic [4:0]          data_out;
    logic [9:0]          code_out;
    logic [3:0]          error_index;
    logic                multiple_error;
    logic [CNT_W_TB-1:0] corr_cnt;
    logic [CNT_W_TB-1:0] uncorr_cnt;

    int checks   = 0;
    int failures = 0;

    hamming_serial_decoder #(.CNT_W(CNT_W_TB)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr            (clr),
        .in_valid       (in_valid),
        .in_bit         (in_bit),
        .in_ready       (in_ready),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .data_out       (data_out),
        .code_out       (code_out),
        .error_index    (error_index),
        .multiple_error (multiple_error),
        .corr_cnt       (corr_cnt),
        .uncorr_cnt     (uncorr_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Shift out c[9] first; leaves the bench 1 unit after the edge taking c[0].
    task automatic send_bits(input logic [9:0] w, input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_bit   = w[9 - i];
            step();
        end
        in_valid = 1'b0;
        in_bit   = 1'b0;
    endtask

    // DECODE cycle, then HOLD outputs, then (with out_ready=1) release.
    task automatic expect_word(input string tag, input logic [9:0] w,
                               input logic [9:0] code, input logic [4:0] data,
                               input logic [3:0] idx, input logic multi);
        send_bits(w, 10);
        check({tag, ".decode_valid"}, 32'(out_valid), 32'd0);
        check({tag, ".decode_ready"}, 32'(in_ready), 32'd0);
        step();
        check({tag, ".valid"}, 32'(out_valid), 32'd1);
        check({tag, ".code"},  32'(code_out), 32'(code));
        check({tag, ".data"},  32'(data_out), 32'(data));
        check({tag, ".index"}, 32'(error_index), 32'(idx));
        check({tag, ".multi"}, 32'(multiple_error), 32'(multi));
        if (out_ready) begin
            step();
            check({tag, ".release"}, 32'(out_valid), 32'd0);
            check({tag, ".ready_again"}, 32'(in_ready), 32'd1);
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        clr       = 1'b0;
        in_valid  = 1'b0;
        in_bit    = 1'b0;
        out_ready = 1'b0;
        step();
        step();
        check("rst.out_valid", 32'(out_valid), 32'd0);
        check("rst.in_ready",  32'(in_ready), 32'd1);
        check("rst.data",      32'(data_out), 32'd0);
        check("rst.code",      32'(code_out), 32'd0);
        check("rst.index",     32'(error_index), 32'd0);
        check("rst.multi",     32'(multiple_error), 32'd0);
        check("rst.corr",      32'(corr_cnt), 32'd0);
        check("rst.uncorr",    32'(uncorr_cnt), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        step();

        expect_word("clean",   10'h198, 10'h198, 5'b10110, 4'd0,  1'b0);
        expect_word("err_c5",  10'h1B8, 10'h198, 5'b10110, 4'd5,  1'b0);
        expect_word("err_c0",  10'h199, 10'h198, 5'b10110, 4'd10, 1'b0);
        expect_word("dbl",     10'h390, 10'h390, 5'b10100, 4'd0,  1'b1);
        expect_word("err_c9",  10'h266, 10'h066, 5'b01001, 4'd1,  1'b0);
        expect_word("syn_ge10",10'h2E2, 10'h2E2, 5'b11001, 4'd0,  1'b1);

        // Backpressure: hold 5 cycles while in_valid bits are offered.
        out_ready = 1'b0;
        expect_word("bp", 10'h1B8, 10'h198, 5'b10110, 4'd5, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_bit   = i[0];
            step();
            check("bp.hold_valid", 32'(out_valid), 32'd1);
            check("bp.hold_ready", 32'(in_ready), 32'd0);
            check("bp.hold_code",  32'(code_out), 32'h198);
            check("bp.hold_index", 32'(error_index), 32'd5);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("bp.release", 32'(out_valid), 32'd0);
        expect_word("bp_next", 10'h198, 10'h198, 5'b10110, 4'd0, 1'b0);

`ifdef HAMMING_DEC_STATS_EN
        check("stats.corr_sat", 32'(corr_cnt), 32'd3);
        check("stats.uncorr",   32'(uncorr_cnt), 32'd2);
`else
        check("stats.corr_off",   32'(corr_cnt), 32'd0);
        check("stats.uncorr_off", 32'(uncorr_cnt), 32'd0);
`endif

        // Asynchronous reset mid-word.
        send_bits(10'h3FF, 4);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst.out_valid", 32'(out_valid), 32'd0);
        check("arst.data",      32'(data_out), 32'd0);
        check("arst.code",      32'(code_out), 32'd0);
        check("arst.index",     32'(error_index), 32'd0);
        check("arst.corr",      32'(corr_cnt), 32'd0);
        check("arst.uncorr",    32'(uncorr_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        expect_word("after_rst", 10'h198, 10'h198, 5'b10110, 4'd0, 1'b0);

        // clr mid-word.
        send_bits(10'h3FF, 4);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr.in_ready",  32'(in_ready), 32'd1);
        check("clr.out_valid", 32'(out_valid), 32'd0);
        expect_word("after_clr", 10'h198, 10'h198, 5'b10110, 4'd0, 1'b0);

        // clr while holding a word drops it.
        out_ready = 1'b0;
        expect_word("clr_hold", 10'h199, 10'h198, 5'b10110, 4'd10, 1'b0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_hold.valid", 32'(out_valid), 32'd0);
        check("clr_hold.ready", 32'(in_ready), 32'd1);
        out_ready = 1'b1;
        expect_word("after_clr_hold", 10'h066, 10'h066, 5'b01001, 4'd0, 1'b0);

`ifdef HAMMING_DEC_STATS_EN
        check("stats.corr_post",   32'(corr_cnt), 32'd1);
        check("stats.uncorr_post", 32'(uncorr_cnt), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
